// File: rtl/vga_pkg.sv
// Shared VGA framebuffer definitions.
// Holds the 160x120 framebuffer geometry and the common width constants.
// It also holds the pixel and framebuffer-write record types. The clear and
// sine generators, this writer and the scan-out reader all use these types.
package vga_pkg;

    localparam int H_RES   = 160;
    localparam int V_RES   = 120;
    localparam int XW      = 8;
    localparam int YW      = 8;
    localparam int CW      = 12;
    localparam int AW      = 15;
    localparam int FB_SIZE = H_RES * V_RES;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] color;
    } pixel_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/pixel_fb_writer_if.sv
// Pixel stream interface between the pixel source mux and the framebuffer writer.
//   in_valid  : source offers a pixel
//   in_ready  : sink can take a pixel this cycle
//   CounterX  : pixel column
//   CounterY  : pixel row
//   color     : 4:4:4 RGB colour
// The master modport is the pixel source. The slave modport is the writer.
interface pixel_fb_writer_if;
    import vga_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] CounterX;
    logic [YW-1:0] CounterY;
    logic [CW-1:0] color;

    modport master (output in_valid, CounterX, CounterY, color, input in_ready);
    modport slave  (input in_valid, CounterX, CounterY, color, output in_ready);

endinterface

// File: rtl/pix_fifo.sv
// Small synchronous FIFO holding pending framebuffer writes.
//   clk, rst_n : clock and synchronous active-low reset
//   i_push     : write i_data at the tail
//   i_data     : entry to push
//   i_pop      : drop the head entry
//   o_count    : number of stored entries (0..DEPTH)
//   o_head     : current head entry (undefined when empty)
// The FIFO does not check flow. The caller never pushes when full and never
// pops when empty. DEPTH must be a power of two so that the pointers wrap
// naturally.
module pix_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [W-1:0]               o_head
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; o_count decides what is meaningful.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pixel_fb_writer.sv
// Framebuffer writer: pixel stream -> 160x120x12 framebuffer write port.
// Each accepted pixel is registered (S1) together with its range check and
// its linear address y*H_RES+x. Pixels that are in range are buffered in
// pix_fifo. The FIFO head drives the RAM write port whenever the arbiter
// does not stall.
//   clk, rst_n : clock and synchronous active-low reset
//   pix        : pixel stream, slave side (in_valid/in_ready/CounterX/CounterY/color)
//   fb_stall   : RAM port unavailable this cycle
//   fb_we      : write strobe
//   fb_addr    : write address (FIFO head, 0 when empty)
//   fb_data    : write data (FIFO head, 0 when empty)
//   idle       : nothing in S1 and nothing buffered
//   drop_cnt   : saturating count of discarded out-of-range pixels
// Optional macro PIX_DROP_CNT_EN enables drop_cnt. Without it, drop_cnt is 0.
module pixel_fb_writer import vga_pkg::*; #(
    parameter int H_RES = vga_pkg::H_RES,
    parameter int V_RES = vga_pkg::V_RES,
    parameter int XW    = vga_pkg::XW,
    parameter int YW    = vga_pkg::YW,
    parameter int CW    = vga_pkg::CW,
    parameter int AW    = vga_pkg::AW,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pixel_fb_writer_if.slave    pix,
    input  logic                fb_stall,
    output logic                fb_we,
    output logic [AW-1:0]       fb_addr,
    output logic [CW-1:0]       fb_data,
    output logic                idle,
    output logic [15:0]         drop_cnt
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic                w_hs;
    logic                w_in_range;
    logic [31:0]         w_addr_full;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_nempty;
    logic [CNTW-1:0]     w_count;
    logic [AW+CW-1:0]    w_head;

    logic                r_vld_p1;
    logic                r_in_range_p1;
    logic [AW-1:0]       r_addr_p1;
    logic [CW-1:0]       r_color_p1;

    assign w_hs       = pix.in_valid && pix.in_ready;
    assign w_in_range = (32'(pix.CounterX) < 32'(H_RES)) && (32'(pix.CounterY) < 32'(V_RES));

    // 160 = 128 + 32, so the default geometry needs no multiplier.
    generate
        if (H_RES == 160) begin : g_addr_shift
            assign w_addr_full = (32'(pix.CounterY) << 7) + (32'(pix.CounterY) << 5)
                               + 32'(pix.CounterX);
        end else begin : g_addr_mul
            assign w_addr_full = 32'(pix.CounterY) * 32'(H_RES) + 32'(pix.CounterX);
        end
    endgenerate

    // ---- S1: registered pixel, range flag and linear address ----
    always_ff @(posedge clk) begin
        if (!rst_n) r_vld_p1 <= 1'b0;
        else        r_vld_p1 <= w_hs;
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_in_range_p1 <= w_in_range;
            r_addr_p1     <= w_addr_full[AW-1:0];
            r_color_p1    <= pix.color;
        end
    end

    // ---- FIFO: buffered writes awaiting the RAM port ----
    assign w_push = r_vld_p1 && r_in_range_p1;
    assign w_pop  = fb_we;

    pix_fifo #(
        .W     (AW + CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_addr_p1, r_color_p1}),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // A FIFO slot is reserved for the pixel sitting in S1. A push can then
    // never find the FIFO full, and in_ready uses only registered state.
    assign pix.in_ready  = ({1'b0, w_count} + {{CNTW{1'b0}}, r_vld_p1}) < (CNTW+1)'(DEPTH);

    assign w_fifo_nempty = (w_count != '0);
    assign fb_we         = w_fifo_nempty && !fb_stall;
    assign fb_addr       = w_fifo_nempty ? w_head[AW+CW-1:CW] : '0;
    assign fb_data       = w_fifo_nempty ? w_head[CW-1:0]     : '0;
    assign idle          = !w_fifo_nempty && !r_vld_p1;

`ifdef PIX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_drop_cnt <= '0;
        else if (r_vld_p1 && !r_in_range_p1 && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: table of single pixels, then
// back-pressure, simultaneous push/pop, reset mid-operation and a full frame.
module tb_pixel_fb_writer;
    import vga_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        fb_stall;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic        idle;
    logic [15:0] drop_cnt;

    pixel_fb_writer_if bus ();

    pixel_fb_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix      (bus.slave),
        .fb_stall (fb_stall),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .idle     (idle),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int n_writes;

    fb_wr_t exp_q[$];

    logic        s_we, s_ready, s_idle;
    logic [14:0] s_addr;
    logic [11:0] s_data;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
        logic        inr;
        logic [14:0] addr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic drive_cycle(input logic v, input logic [7:0] x, input logic [7:0] y,
                               input logic [11:0] c, input logic st, output logic hs);
        int a;
        bus.in_valid = v;
        bus.CounterX = x;
        bus.CounterY = y;
        bus.color    = c;
        fb_stall     = st;
        @(negedge clk);
        hs      = v && bus.in_ready;
        s_we    = fb_we;
        s_ready = bus.in_ready;
        s_idle  = idle;
        s_addr  = fb_addr;
        s_data  = fb_data;
        if (hs && (x < 8'd160) && (y < 8'd120)) begin
            a = int'(y) * 160 + int'(x);
            exp_q.push_back('{addr: 15'(a), data: c});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic hs;
        int   guard;
        guard = 0;
        do begin
            drive_cycle(1'b0, 8'd0, 8'd0, 12'd0, 1'b0, hs);
            guard++;
        end while (!s_idle && guard < 40);
        chk({name, "_drained"}, 32'(s_idle), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every write must match the oldest accepted in-range pixel.
    always @(negedge clk) begin
        if (rst_n && fb_we === 1'b1) begin
            fb_wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0h exp=none", fb_addr, fb_data);
            end else begin
                e = exp_q.pop_front();
                if (fb_addr !== e.addr || fb_data !== e.data) begin
                    errors++;
                    $display("FAIL write_order addr=%0d data=%0h exp addr=%0d data=%0h",
                             fb_addr, fb_data, e.addr, e.data);
                end
            end
            n_writes++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic hs;
        int   xb, hs_cnt, gaps, w0, guard;

        tbl[0] = '{8'd5,   8'd2,   12'hF00, 1'b1, 15'd325};
        tbl[1] = '{8'd160, 8'd0,   12'h111, 1'b0, 15'd0};
        tbl[2] = '{8'd0,   8'd120, 12'h222, 1'b0, 15'd0};
        tbl[3] = '{8'd255, 8'd255, 12'h333, 1'b0, 15'd0};
        tbl[4] = '{8'd159, 8'd119, 12'hABC, 1'b1, 15'd19199};
        tbl[5] = '{8'd0,   8'd0,   12'h123, 1'b1, 15'd0};
        tbl[6] = '{8'd159, 8'd0,   12'h0F0, 1'b1, 15'd159};
        tbl[7] = '{8'd0,   8'd1,   12'h00F, 1'b1, 15'd160};
        tbl[8] = '{8'd10,  8'd100, 12'h5A5, 1'b1, 15'd16010};

        checks = 0; errors = 0; n_writes = 0;
        rst_n = 1'b0;
        fb_stall = 1'b0;
        bus.in_valid = 1'b0;
        bus.CounterX = '0;
        bus.CounterY = '0;
        bus.color = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single pixels: write exactly two cycles after the handshake.
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b1, tbl[i].x, tbl[i].y, tbl[i].c, 1'b0, hs);
            chk($sformatf("vec%0d_accept", i), 32'(hs), 32'd1);
            drive_cycle(1'b0, 8'd0, 8'd0, 12'd0, 1'b0, hs);
            chk($sformatf("vec%0d_we_c1", i), 32'(s_we), 32'd0);
            drive_cycle(1'b0, 8'd0, 8'd0, 12'd0, 1'b0, hs);
            chk($sformatf("vec%0d_we_c2", i), 32'(s_we), 32'(tbl[i].inr));
            if (tbl[i].inr) begin
                chk($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(tbl[i].addr));
                chk($sformatf("vec%0d_data", i), 32'(s_data), 32'(tbl[i].c));
            end
            drive_cycle(1'b0, 8'd0, 8'd0, 12'd0, 1'b0, hs);
            chk($sformatf("vec%0d_idle_c3", i), 32'(s_idle), 32'd1);
            chk($sformatf("vec%0d_we_c3", i), 32'(s_we), 32'd0);
        end
`ifdef PIX_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'd3);
`else
        chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Back-pressure: four handshakes while stalled, head holds address 0.
        xb = 0; hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 8'(xb), 8'd0, 12'(xb * 3 + 1), 1'b1, hs);
            if (hs) begin xb++; hs_cnt++; end
        end
        chk("bp_handshakes", 32'(hs_cnt), 32'd4);
        chk("bp_ready_low", 32'(s_ready), 32'd0);
        chk("bp_we_low", 32'(s_we), 32'd0);
        chk("bp_head_addr", 32'(s_addr), 32'd0);
        chk("bp_head_data", 32'(s_data), 32'd1);
        w0 = n_writes; gaps = 0; guard = 0;
        while (xb < 12 && guard < 60) begin
            drive_cycle(1'b1, 8'(xb), 8'd0, 12'(xb * 3 + 1), 1'b0, hs);
            if (hs) xb++;
            if (!s_we) gaps++;
            guard++;
        end
        chk("bp_no_gap", 32'(gaps), 32'd0);
        drain("bp");
        chk("bp_write_count", 32'(n_writes - w0), 32'd12);

        // Simultaneous push/pop with two entries buffered.
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(20 + i), 8'd3, 12'h0A0, 1'b0, hs);
        drive_cycle(1'b1, 8'd24, 8'd3, 12'h0A0, 1'b1, hs);
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 8'(25 + i), 8'd3, 12'h0A0, 1'b0, hs);
            if (!s_we || !s_ready || !hs) gaps++;
        end
        chk("pp_continuous", 32'(gaps), 32'd0);
        w0 = n_writes;
        drain("pp");
        chk("pp_tail_writes", 32'(n_writes - w0), 32'd3);

        // Reset while full and stalled.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'(i), 8'd5, 12'hFFF, 1'b1, hs);
        chk("mr_full_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fb_stall = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mr_fb_we", 32'(fb_we), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mr_idle", 32'(idle), 32'd1);
        chk("mr_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mr_fb_addr", 32'(fb_addr), 32'd0);
        @(posedge clk);
        #1;
        w0 = n_writes;
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 8'd0, 8'd0, 12'd0, 1'b0, hs);
        chk("mr_no_stale", 32'(n_writes - w0), 32'd0);

        // Full clear frame under random stall.
        w0 = n_writes;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                guard = 0;
                do begin
                    drive_cycle(1'b1, 8'(x), 8'(y), 12'h000, ($urandom_range(0, 99) < 30), hs);
                    guard++;
                end while (!hs && guard < 50);
                if (!hs) chk("frame_accept", 32'(hs), 32'd1);
            end
        end
        drain("frame");
        chk("frame_writes", 32'(n_writes - w0), 32'(FB_SIZE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
